// File: rtl/uart_rx_word_asm.sv
// uart_rx_word_asm
// Packs NBYTES bytes from the uart_rx byte receiver into one word, then hands
// the word to a word-wide sink over a valid/ready handshake. The output stage
// holds one word. The block also keeps a saturating count of delivered words,
// a sticky threshold flag and a sticky overflow flag.
//
// Build option: define UART_RX_WORD_ASM_TIMEOUT_EN to build the inter-byte
// timeout. When a partial word sits idle for TIMEOUT_CLKS cycles, the timeout
// discards it and realigns framing to byte 0. Without the macro, o_timeout is
// tied low and a partial word waits for its remaining bytes indefinitely.
module uart_rx_word_asm #(
    parameter int NBYTES       = 4,
    parameter int MSB_FIRST    = 1,
    parameter int CNT_W        = 32,
    parameter int THRESH       = 500,
    parameter int TIMEOUT_CLKS = 6250
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [7:0]            i_rxbyte,
    input  logic                  i_rxdatval,
    output logic [8*NBYTES-1:0]   o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_thresh,
    output logic                  o_overflow,
    output logic                  o_timeout
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0]    ZERO_IDX   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]    ONE_IDX    = IDX_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    // The threshold is compared in a wider domain. A THRESH above the
    // counter's range then simply never fires.
    localparam logic [CNT_W+31:0]   THRESH_EXT = (CNT_W + 32)'(THRESH);

    // Bytes per word must fit the 2..8 range, and the timeout needs at least one cycle.
    generate
        if ((NBYTES < 2) || (NBYTES > 8)) begin : g_bad_nbytes
            $error("uart_rx_word_asm: NBYTES must be in 2..8");
        end
        if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
            $error("uart_rx_word_asm: TIMEOUT_CLKS must be at least 1");
        end
    endgenerate

    // Low bit position of byte slot k within the word, for the chosen byte order.
    function automatic int slot_lo(input int k);
        if (MSB_FIRST != 0) begin
            return W - 8 - 8 * k;
        end else begin
            return 8 * k;
        end
    endfunction

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Assembly side
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     asm_q,   asm_d;
    logic             complete_s;
    logic [W-1:0]     word_s;

    // Output side
    out_state_e       state_q, state_d;
    logic [W-1:0]     data_q,  data_d;
    logic             overflow_q, overflow_d;
    logic             xfer_s;

    // Statistics
    logic [CNT_W-1:0] count_q, count_d;
    logic             thresh_q, thresh_d;

`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
    localparam int               TMR_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;
`endif

    // Byte slotting, word-completion detection and (optionally) inter-byte timeout.
    always_comb begin
        idx_d      = idx_q;
        asm_d      = asm_q;
        complete_s = 1'b0;
`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
        timer_d    = timer_q;
        timeout_d  = 1'b0;
`endif
        if (i_rxdatval) begin
            // Only the slot selected by idx takes the new byte; the others keep their contents.
            for (int k = 0; k < NBYTES; k++) begin
                asm_d[slot_lo(k) +: 8] = (idx_q == IDX_W'(k)) ? i_rxbyte
                                                               : asm_q[slot_lo(k) +: 8];
            end
            if (idx_q == LAST_IDX) begin
                idx_d      = ZERO_IDX;
                complete_s = 1'b1;
            end else begin
                idx_d      = idx_q + ONE_IDX;
                complete_s = 1'b0;
            end
`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
            timer_d = TMR_ZERO;
`endif
        end else begin
`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
            // The timer runs only while a partial word is pending.
            // A strobe on the expiry cycle takes the branch above and so wins over the timeout.
            if (idx_q != ZERO_IDX) begin
                if (timer_q == TMR_LAST) begin
                    idx_d     = ZERO_IDX;
                    asm_d     = {W{1'b0}};
                    timer_d   = TMR_ZERO;
                    timeout_d = 1'b1;
                end else begin
                    timer_d   = timer_q + TMR_ONE;
                    timeout_d = 1'b0;
                end
            end else begin
                timer_d = TMR_ZERO;
            end
`else
            idx_d = idx_q;
`endif
        end
        // The completed word includes the byte that arrives this cycle.
        word_s = asm_d;
    end

    // Output holding register: next-state and load/drop decisions for EMPTY/FULL.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        xfer_s     = (state_q == ST_FULL) && i_ready;
        case (state_q)
            ST_EMPTY: begin
                if (complete_s) begin
                    state_d = ST_FULL;
                    data_d  = word_s;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (complete_s) begin
                    // A transfer this cycle frees the register for the new word.
                    // Without a transfer, the new word is lost.
                    if (i_ready) begin
                        state_d = ST_FULL;
                        data_d  = word_s;
                    end else begin
                        state_d    = ST_FULL;
                        overflow_d = 1'b1;
                    end
                end else if (i_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Delivered-word counter (saturating) and sticky threshold flag.
    always_comb begin
        count_d  = count_q;
        thresh_d = thresh_q;
        if (xfer_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
        // Compare against the next count so the flag rises together with the count register.
        thresh_d = thresh_q | ({32'd0, count_d} >= THRESH_EXT);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            idx_q      <= ZERO_IDX;
            asm_q      <= {W{1'b0}};
            state_q    <= ST_EMPTY;
            data_q     <= {W{1'b0}};
            overflow_q <= 1'b0;
            count_q    <= {CNT_W{1'b0}};
            thresh_q   <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            asm_q      <= asm_d;
            state_q    <= state_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            thresh_q   <= thresh_d;
        end
    end

`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
    // Inter-byte timer and timeout pulse registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            timer_q   <= TMR_ZERO;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_data     = data_q;
    assign o_valid    = (state_q == ST_FULL);
    assign o_count    = count_q;
    assign o_thresh   = thresh_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_word_asm.sv
// Directed bench for uart_rx_word_asm.
// Instance A uses the default parameters (MSB first, 32-bit count).
// Instance B shares A's stimulus and uses LSB first, CNT_W=2 and THRESH=3, which exercises
// saturation and the threshold. Both instances use TIMEOUT_CLKS=16.
// Expected words are queued as stimulus is sent and are popped when a transfer is seen.
module tb_uart_rx_word_asm;

    logic        clk    = 1'b0;
    logic        rstn   = 1'b0;
    logic [7:0]  rxbyte = 8'h00;
    logic        rxdatval = 1'b0;
    logic        ready  = 1'b0;

    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic [31:0] count_a;
    logic [1:0]  count_b;
    logic        thresh_a, thresh_b, ovf_a, ovf_b, to_a, to_b;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          exp_cnt_a = 0;
    int          exp_cnt_b = 0;
    int          to_pulses = 0;
    int          base;

    uart_rx_word_asm #(
        .NBYTES(4), .MSB_FIRST(1), .CNT_W(32), .THRESH(500), .TIMEOUT_CLKS(16)
    ) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_rxbyte(rxbyte), .i_rxdatval(rxdatval),
        .o_data(data_a), .o_valid(valid_a), .i_ready(ready), .o_count(count_a),
        .o_thresh(thresh_a), .o_overflow(ovf_a), .o_timeout(to_a)
    );

    uart_rx_word_asm #(
        .NBYTES(4), .MSB_FIRST(0), .CNT_W(2), .THRESH(3), .TIMEOUT_CLKS(16)
    ) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_rxbyte(rxbyte), .i_rxdatval(rxdatval),
        .o_data(data_b), .o_valid(valid_b), .i_ready(ready), .o_count(count_b),
        .o_thresh(thresh_b), .o_overflow(ovf_b), .o_timeout(to_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rxbyte   = b;
        rxdatval = 1'b1;
        @(posedge clk);
        #1;
        rxdatval = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and counter model, sampled on the falling edge.
    always @(negedge clk) begin
        logic [31:0] w;
        check("count_a", {32'd0, count_a}, 64'(exp_cnt_a));
        check("count_b", {62'd0, count_b}, 64'(exp_cnt_b));
        check("thresh_a", {63'd0, thresh_a}, {63'd0, (exp_cnt_a >= 500)});
        check("thresh_b", {63'd0, thresh_b}, {63'd0, (exp_cnt_b >= 3)});
        if (to_a) to_pulses++;
        if (!rstn) begin
            exp_cnt_a = 0;
            exp_cnt_b = 0;
        end else if (valid_a && ready) begin
            check("sb_nonempty", {63'd0, (exp_q.size() != 0)}, 64'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("word_a", {32'd0, data_a}, {32'd0, w});
                check("word_b", {32'd0, data_b}, {32'd0, bswap(w)});
                check("valid_b", {63'd0, valid_b}, 64'd1);
            end
            exp_cnt_a++;
            if (exp_cnt_b < 3) exp_cnt_b++;
        end
    end

    initial begin
        // Reset
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rst_data_a",  {32'd0, data_a}, 64'd0);
        check("rst_valid_a", {63'd0, valid_a}, 64'd0);
        check("rst_count_a", {32'd0, count_a}, 64'd0);
        check("rst_ovf_a",   {63'd0, ovf_a}, 64'd0);
        check("rst_to_a",    {63'd0, to_a}, 64'd0);
        check("rst_data_b",  {32'd0, data_b}, 64'd0);
        check("rst_thresh_b", {63'd0, thresh_b}, 64'd0);

        // Byte order and one-cycle latency
        ready = 1'b1;
        exp_q.push_back(32'h12345678);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check("no_early_valid", {63'd0, valid_a}, 64'd0);
        send_byte(8'h78);
        check("order_valid", {63'd0, valid_a}, 64'd1);
        check("order_msb", {32'd0, data_a}, 64'h12345678);
        check("order_lsb", {32'd0, data_b}, 64'h78563412);
        idle();
        check("order_valid_drop", {63'd0, valid_a}, 64'd0);

        // Completion coinciding with a transfer
        ready = 1'b0;
        exp_q.push_back(32'hA1A2A3A4);
        exp_q.push_back(32'hB1B2B3B4);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
        ready = 1'b1;
        send_byte(8'hB4);
        check("b2b_valid_held", {63'd0, valid_a}, 64'd1);
        check("b2b_new_word", {32'd0, data_a}, 64'hB1B2B3B4);
        check("b2b_no_ovf", {63'd0, ovf_a}, 64'd0);

        // Continuous words with ready held high (B saturates at 3)
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b0;
            b0 = 8'h40 + 8'(i * 16);
            exp_q.push_back({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
            for (int j = 0; j < 4; j++) send_byte(b0 + 8'(j));
        end
        idle();
        check("stream_valid_drop", {63'd0, valid_a}, 64'd0);

        // Stall and overflow
        ready = 1'b0;
        exp_q.push_back(32'h01020304);
        for (int j = 1; j <= 8; j++) send_byte(8'(j));
        check("stall_hold", {32'd0, data_a}, 64'h01020304);
        check("stall_valid", {63'd0, valid_a}, 64'd1);
        check("stall_ovf_a", {63'd0, ovf_a}, 64'd1);
        check("stall_ovf_b", {63'd0, ovf_b}, 64'd1);
        ready = 1'b1;
        idle();
        check("stall_drain", {63'd0, valid_a}, 64'd0);
        check("count_after_stall", {32'd0, count_a}, 64'd7);
        check("count_sat_b", {62'd0, count_b}, 64'd3);

        // Inter-byte timeout / partial-word wait
        base = to_pulses;
`ifdef UART_RX_WORD_ASM_TIMEOUT_EN
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (20) idle();
        check("to_pulse_once", 64'(to_pulses - base), 64'd1);
        exp_q.push_back(32'hAABBCCDD);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle();
        base = to_pulses;
        exp_q.push_back(32'h31323334);
        send_byte(8'h31);
        send_byte(8'h32);
        repeat (15) idle();
        send_byte(8'h33);
        send_byte(8'h34);
        repeat (2) idle();
        check("to_edge_no_pulse", 64'(to_pulses - base), 64'd0);
`else
        exp_q.push_back(32'h11223344);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (20) idle();
        send_byte(8'h33);
        send_byte(8'h44);
        repeat (2) idle();
        check("no_timeout_pulse", 64'(to_pulses - base), 64'd0);
`endif

        // Mid-word reset with a held word pending
        ready = 1'b0;
        send_byte(8'h51); send_byte(8'h52); send_byte(8'h53); send_byte(8'h54);
        send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
        rstn = 1'b0;
        idle();
        rstn = 1'b1;
        check("mrst_valid", {63'd0, valid_a}, 64'd0);
        check("mrst_data", {32'd0, data_a}, 64'd0);
        check("mrst_count", {32'd0, count_a}, 64'd0);
        check("mrst_ovf", {63'd0, ovf_a}, 64'd0);
        check("mrst_thresh_b", {63'd0, thresh_b}, 64'd0);
        check("mrst_to", {63'd0, to_a}, 64'd0);
        ready = 1'b1;
        exp_q.push_back(32'h71727374);
        send_byte(8'h71); send_byte(8'h72); send_byte(8'h73); send_byte(8'h74);
        check("mrst_align", {32'd0, data_a}, 64'h71727374);
        repeat (2) idle();
        check("mrst_count_after", {32'd0, count_a}, 64'd1);

        repeat (3) idle();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_word_asm.md
# uart_rx_word_asm

Parametrised byte-to-word assembler that sits between the `uart_rx` byte receiver and a word-wide sink such as the sample FIFO or BRAM writer. It packs `NBYTES` received bytes into one word in a configurable byte order. It delivers each word over a valid/ready handshake with one word of buffering, and maintains a delivered-word counter with a sticky threshold flag. It also reports overflow and, when compiled in, an inter-byte timeout that resynchronises framing.

## Interface
- `NBYTES`, 4: bytes per word, 2..8; word width W = 8*NBYTES.
- `MSB_FIRST`, 1: 1 = first received byte lands in bits [W-1:W-8]; 0 = first byte lands in bits [7:0].
- `CNT_W`, 32: width of `o_count`.
- `THRESH`, 500: word count at which `o_thresh` sets.
- `TIMEOUT_CLKS`, 6250: idle cycles after which a partial word is discarded (only used with timeout enabled).

Reset is `i_rstn`, synchronous, active-low; the clock is `i_clk`.

- `i_clk` in 1: clock.
- `i_rstn` in 1: synchronous active-low reset.
- `i_rxbyte` in 8: received byte, qualified by `i_rxdatval`.
- `i_rxdatval` in 1: one-cycle strobe per received byte.
- `o_data` out W: assembled word, stable while `o_valid`=1.
- `o_valid` out 1: word available.
- `i_ready` in 1: sink accepts; a transfer occurs when `o_valid`=1 and `i_ready`=1.
- `o_count` out CNT_W: number of words transferred, saturating at all-ones.
- `o_thresh` out 1: sticky; set once `o_count` ≥ THRESH.
- `o_overflow` out 1: sticky; set when a completed word is dropped.
- `o_timeout` out 1: one-cycle pulse when a partial word is discarded.

## Operation
- **Reset values.** `o_data`=0, `o_valid`=0, `o_count`=0, `o_thresh`=0, `o_overflow`=0, `o_timeout`=0. Internally, byte index `idx`=0, assembly register=0, timer=0.
- **Reset mid-word.** Reset discards any partial word and any held output word.
- **Assembly.** Each `i_rxdatval` stores `i_rxbyte` at slot `idx`, then:
  - if `idx` < NBYTES-1, `idx` increments;
  - if `idx` = NBYTES-1, the word is complete and `idx` returns to 0.
- **Slot placement.**
  - `MSB_FIRST`=1: slot k occupies bits [W-1-8k : W-8-8k].
  - `MSB_FIRST`=0: slot k occupies bits [8k+7 : 8k].
- **Output register states.** EMPTY (`o_valid`=0) and FULL (`o_valid`=1).
- **On word completion:**
  - In EMPTY, or in FULL with a same-cycle transfer: load the completed word into `o_data` and set `o_valid`=1.
  - In FULL with no transfer: drop the completed word, set `o_overflow`; `o_data` is unchanged.
- **Transfer without completion.** `o_valid` goes to 0 next cycle.
- **Sink independence.** Assembly never stalls for the sink; bytes are always accepted.
- **Counter.** `o_count` increments by 1 on each transfer and saturates at 2^CNT_W-1. `o_thresh` sets in the same cycle the count register reaches or exceeds THRESH.
- **Boundary cases.**
  - THRESH=0: `o_thresh` sets on the first cycle after reset.
  - NBYTES must be at least 2; reject NBYTES < 2 at elaboration.

## Timing
- Latency: `o_valid` rises the cycle after the last byte strobe of a word.
- Throughput: one word per NBYTES strobes. No bubble between consecutive words when `i_ready` is held high.
- `o_data` and `o_valid` are registered outputs; `i_ready` has no combinational path to any output.
- Simultaneous completion and transfer: the old word is transferred, the new word is loaded, and `o_valid` stays at 1.
- Timeout (when enabled):
  - The timer runs only while `idx`≠0 and clears on every byte strobe.
  - If the timer equals TIMEOUT_CLKS-1 and no strobe arrives that cycle, then next cycle: `idx`=0, the assembly register clears, and `o_timeout` pulses for 1 cycle.
  - A strobe arriving on that same cycle is accepted normally, and no timeout occurs.
  - The output register is unaffected by timeout.

## Configuration
- Macro: `UART_RX_WORD_ASM_TIMEOUT_EN`.
- Defined: the inter-byte timeout timer, sized by `$clog2(TIMEOUT_CLKS)`, is built and behaves as described above.
- Undefined: no timer logic is built, `o_timeout` is tied to 0, and a partial word waits indefinitely for its remaining bytes.

## Test plan
- **Byte order.** Defaults, `i_ready`=1, bytes 0x12, 0x34, 0x56, 0x78 → `o_data`=0x12345678 with `o_valid` for one cycle, one cycle after the 4th strobe, and `o_count`=1. With `MSB_FIRST`=0 → 0x78563412.
- **Stall and overflow.** `i_ready`=0, send 8 bytes 0x01..0x08 → `o_data`=0x01020304 is held and `o_overflow`=1 after the 8th strobe. Raise `i_ready` → one transfer, `o_count`=1.
- **Back-to-back.** Back-to-back words with completion coinciding with a transfer → no drop, `o_valid` stays 1, `o_count` increments once per word.
- **Threshold and saturation.** THRESH=3, CNT_W=2, send 5 words with `i_ready`=1 → `o_thresh` sets when `o_count`=3, and `o_count` stays at 3 afterwards.
- **Timeout.** Timeout enabled, TIMEOUT_CLKS=16: send 2 bytes, idle 20 cycles, then send 0xAA, 0xBB, 0xCC, 0xDD → `o_timeout` pulses once and the next word is 0xAABBCCDD. Repeat with the third byte arriving exactly on the timeout cycle → no pulse.
- **Mid-word reset.** Assert `i_rstn`=0 for 1 cycle after 3 bytes → all outputs return to reset values, and the next 4 bytes form a correctly aligned word.
